// File: rtl/jt7759_rom_pkg.sv
// Shared constants for the JT7759 ROM responder: FSM encoding, address
// field widths and the little-endian byte picker.
package jt7759_rom_pkg;

    localparam int BA_W  = 17;
    localparam int WA_W  = 16;
    localparam int TAG_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_DEMAND = 3'b010,
        ST_PREF   = 3'b100
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/jt7759_rom.sv
// Byte-wide ROM responder for jt7759_ctrl: two-line direct-mapped word cache
// in front of a 16-bit req/valid external port, with optional next-word prefetch.
//
// Handshake: ext_req/ext_addr are held stable from assertion through the cycle
// where ext_valid pulses; that pulse retires the request and is never aborted.
module jt7759_rom
    import jt7759_rom_pkg::*;
#(
    parameter bit PREFETCH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                rom_cs,
    input  logic [BA_W-1:0]     rom_addr,
    output logic [7:0]          rom_data,
    output logic                rom_ok,
    output logic                ext_req,
    output logic [WA_W-1:0]     ext_addr,
    input  logic [15:0]         ext_data,
    input  logic                ext_valid
);

    state_t            state, state_nxt;
    logic [1:0]        line_vld;
    logic [TAG_W-1:0]  line_tag  [2];
    logic [15:0]       line_data [2];
    logic [BA_W-1:0]   served_addr, req_addr;
    logic              dvld, discard;

    logic [WA_W-1:0]   wa, nwa;
    logic              hit, pref_need, fill_ok, do_hit, do_miss;

    assign wa        = rom_addr[16:1];
    assign hit       = line_vld[wa[0]] && (line_tag[wa[0]] == wa[15:1]);
    assign nwa       = req_addr[16:1] + 16'd1;
    assign pref_need = PREFETCH && !(line_vld[nwa[0]] && (line_tag[nwa[0]] == nwa[15:1]));
    // A flush in the same cycle as the data beat also poisons that beat.
    assign fill_ok   = ext_valid && !discard && !flush;
    assign rom_ok    = rom_cs && dvld && (rom_addr == served_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!flush && rom_cs) begin
                    if (hit) begin
                        do_hit = (rom_addr != served_addr) || !dvld;
                    end else begin
                        do_miss   = 1'b1;
                        state_nxt = ST_DEMAND;
                    end
                end
            end
            ST_DEMAND: if (ext_valid) state_nxt = (fill_ok && pref_need) ? ST_PREF : ST_IDLE;
            ST_PREF:   if (ext_valid) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_data    <= '0;
            served_addr <= '0;
            req_addr    <= '0;
            dvld        <= 1'b0;
            discard     <= 1'b0;
            ext_req     <= 1'b0;
            ext_addr    <= '0;
            line_vld    <= '0;
            for (int i = 0; i < 2; i++) begin
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
        end else begin
            if (do_hit) begin
                rom_data    <= byte_sel(line_data[wa[0]], rom_addr[0]);
                served_addr <= rom_addr;
                dvld        <= 1'b1;
            end
            if (do_miss) begin
                req_addr <= rom_addr;
                ext_req  <= 1'b1;
                ext_addr <= wa;
                discard  <= 1'b0;
            end
            // Both DEMAND and PREF fill the line addressed by the held ext_addr.
            if (state != ST_IDLE && fill_ok) begin
                line_vld[ext_addr[0]]  <= 1'b1;
                line_tag[ext_addr[0]]  <= ext_addr[15:1];
                line_data[ext_addr[0]] <= ext_data;
            end
            if (state == ST_DEMAND && ext_valid) begin
                if (fill_ok) begin
                    rom_data    <= byte_sel(ext_data, req_addr[0]);
                    served_addr <= req_addr;
                    dvld        <= 1'b1;
                end
                if (fill_ok && pref_need) ext_addr <= nwa;
                else                      ext_req  <= 1'b0;
                discard <= 1'b0;
            end
            if (state == ST_PREF && ext_valid) begin
                ext_req <= 1'b0;
                discard <= 1'b0;
            end
            if (flush) begin
                line_vld <= '0;
                dvld     <= 1'b0;
                if (state != ST_IDLE && !ext_valid) discard <= 1'b1;
            end
        end
    end

endmodule
